// File: rtl/vsynth_midi_pkg.sv
// Shared MIDI definitions for the synth datapath: field widths, status
// nibbles used by the receive FSM, and voice allocator state encodings.
package vsynth_midi_pkg;

  localparam int NOTE_W = 7;
  localparam int VEL_W  = 7;

  // MIDI status values shared with the receive FSM
  localparam logic [3:0] ST_NOTE_ON  = 4'h9;
  localparam logic [3:0] ST_NOTE_OFF = 4'h8;
  localparam logic [3:0] ST_PROGRAM  = 4'hC;
  localparam logic [7:0] ST_RESET    = 8'hFF;

  // Allocator FSM encodings
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SCAN   = 2'd1;
  localparam logic [1:0] COMMIT = 2'd2;

endpackage

// File: rtl/voice_alloc_age.sv
// voice_age: per-voice saturating age counter. clr wins over inc; all
// updates are qualified by en (the system clock enable).
module voice_age #(
  parameter int AGE_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic             inc,
  output logic [AGE_W-1:0] age
);

  logic [AGE_W-1:0] age_q, age_d;

  // Next age: clear, or increment until all ones then hold
  always_comb begin
    age_d = age_q;
    if (clr)                    age_d = '0;
    else if (inc && age_q != '1) age_d = age_q + 1'b1;
  end

  // Age register
  always_ff @(posedge clk) begin
    if (rst)     age_q <= '0;
    else if (en) age_q <= age_d;
  end

  assign age = age_q;

endmodule

// File: rtl/voice_alloc.sv
// voice_alloc: polyphonic voice allocator. Each accepted event scans all
// voice slots one per ce cycle (match / free / oldest), then commits in a
// single cycle. Optional sustain pedal via `define VOICE_ALLOC_SUSTAIN_EN.
module voice_alloc
  import vsynth_midi_pkg::*;
#(
  parameter int NVOICES = 8,
  parameter int AGE_W   = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      ce,
  input  logic                      evt_valid,
  output logic                      evt_ready,
  input  logic                      evt_on,
  input  logic [NOTE_W-1:0]         evt_note,
  input  logic [VEL_W-1:0]          evt_vel,
  input  logic                      panic,
`ifdef VOICE_ALLOC_SUSTAIN_EN
  input  logic                      sustain,
`endif
  output logic [NVOICES-1:0]        voice_gate,
  output logic [NVOICES*NOTE_W-1:0] voice_note,
  output logic [NVOICES*VEL_W-1:0]  voice_vel,
  output logic [NVOICES-1:0]        voice_trig
);

  localparam int IDX_W = $clog2(NVOICES);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NVOICES - 1);

  logic [1:0]                       state_q, state_d;
  logic                             rdy_q, rdy_d;
  logic [IDX_W-1:0]                 idx_q, idx_d;
  logic                             ev_on_q, ev_on_d;
  logic [NOTE_W-1:0]                ev_note_q, ev_note_d;
  logic [VEL_W-1:0]                 ev_vel_q, ev_vel_d;
  logic                             mfnd_q, mfnd_d, ffnd_q, ffnd_d, ofnd_q, ofnd_d;
  logic [IDX_W-1:0]                 midx_q, midx_d, fidx_q, fidx_d, oidx_q, oidx_d;
  logic [AGE_W-1:0]                 oage_q, oage_d;
  logic [NVOICES-1:0]               gate_q, gate_d, held_q, held_d, trig_q, trig_d;
  logic [NVOICES-1:0][NOTE_W-1:0]   note_q, note_d;
  logic [NVOICES-1:0][VEL_W-1:0]    vel_q, vel_d;
  logic [NVOICES-1:0][AGE_W-1:0]    age_w;
  logic [NVOICES-1:0]               age_clr, age_inc;
  logic [IDX_W-1:0]                 tgt;
  logic                             sus_in;
  logic                             sus_fall;

`ifdef VOICE_ALLOC_SUSTAIN_EN
  logic sus_q;
  assign sus_in   = sustain;
  assign sus_fall = sus_q & ~sustain;
  // Pedal history for falling-edge detection
  always_ff @(posedge clk) begin
    if (rst)     sus_q <= 1'b0;
    else if (ce) sus_q <= sustain;
  end
`else
  assign sus_in   = 1'b0;
  assign sus_fall = 1'b0;
`endif

  // One age counter per voice slot
  for (genvar g = 0; g < NVOICES; g++) begin : g_age
    voice_age #(.AGE_W(AGE_W)) u_age (
      .clk (clk),
      .rst (rst),
      .en  (ce),
      .clr (age_clr[g]),
      .inc (age_inc[g]),
      .age (age_w[g])
    );
  end

  // FSM, scan candidate tracking and voice commit
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    ev_on_d   = ev_on_q;
    ev_note_d = ev_note_q;
    ev_vel_d  = ev_vel_q;
    mfnd_d    = mfnd_q;
    midx_d    = midx_q;
    ffnd_d    = ffnd_q;
    fidx_d    = fidx_q;
    ofnd_d    = ofnd_q;
    oidx_d    = oidx_q;
    oage_d    = oage_q;
    gate_d    = gate_q;
    held_d    = held_q;
    note_d    = note_q;
    vel_d     = vel_q;
    trig_d    = '0;
    age_clr   = '0;
    age_inc   = '0;
    tgt       = mfnd_q ? midx_q : (ffnd_q ? fidx_q : oidx_q);

    if (panic) begin
      // note/vel kept so envelopes can still release on them
      state_d = IDLE;
      gate_d  = '0;
      held_d  = '0;
      age_clr = '1;
    end else begin
      case (state_q)
        IDLE: begin
          if (evt_valid) begin
            ev_on_d   = evt_on;
            ev_note_d = evt_note;
            ev_vel_d  = evt_vel;
            idx_d     = '0;
            mfnd_d    = 1'b0;
            ffnd_d    = 1'b0;
            ofnd_d    = 1'b0;
            oage_d    = '0;
            state_d   = SCAN;
          end
        end
        SCAN: begin
          if (!mfnd_q && held_q[idx_q] && note_q[idx_q] == ev_note_q) begin
            mfnd_d = 1'b1;
            midx_d = idx_q;
          end
          if (!ffnd_q && !gate_q[idx_q]) begin
            ffnd_d = 1'b1;
            fidx_d = idx_q;
          end
          // strict > keeps the lowest index on equal (incl. saturated) ages
          if (gate_q[idx_q] && (!ofnd_q || age_w[idx_q] > oage_q)) begin
            ofnd_d = 1'b1;
            oidx_d = idx_q;
            oage_d = age_w[idx_q];
          end
          if (idx_q == LAST) state_d = COMMIT;
          else               idx_d   = idx_q + 1'b1;
        end
        COMMIT: begin
          state_d = IDLE;
          if (ev_on_q && ev_vel_q != '0) begin
            gate_d[tgt] = 1'b1;
            held_d[tgt] = 1'b1;
            note_d[tgt] = ev_note_q;
            vel_d[tgt]  = ev_vel_q;
            trig_d[tgt] = 1'b1;
            for (int v = 0; v < NVOICES; v++) begin
              if (IDX_W'(v) == tgt) age_clr[v] = 1'b1;
              else if (gate_q[v])   age_inc[v] = 1'b1;
            end
          end else if (mfnd_q) begin
            // vel 0 note-on lands here too (running-status note-off)
            held_d[midx_q] = 1'b0;
            if (!sus_in) gate_d[midx_q] = 1'b0;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    // Pedal release drops every sustained voice regardless of FSM state
    if (sus_fall) gate_d = gate_d & held_d;
  end

  assign rdy_d = (state_d == IDLE);

  // State registers; rst overrides ce, everything else waits for ce
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      rdy_q     <= 1'b1;
      idx_q     <= '0;
      ev_on_q   <= 1'b0;
      ev_note_q <= '0;
      ev_vel_q  <= '0;
      mfnd_q    <= 1'b0;
      midx_q    <= '0;
      ffnd_q    <= 1'b0;
      fidx_q    <= '0;
      ofnd_q    <= 1'b0;
      oidx_q    <= '0;
      oage_q    <= '0;
      gate_q    <= '0;
      held_q    <= '0;
      trig_q    <= '0;
      note_q    <= '0;
      vel_q     <= '0;
    end else if (ce) begin
      state_q   <= state_d;
      rdy_q     <= rdy_d;
      idx_q     <= idx_d;
      ev_on_q   <= ev_on_d;
      ev_note_q <= ev_note_d;
      ev_vel_q  <= ev_vel_d;
      mfnd_q    <= mfnd_d;
      midx_q    <= midx_d;
      ffnd_q    <= ffnd_d;
      fidx_q    <= fidx_d;
      ofnd_q    <= ofnd_d;
      oidx_q    <= oidx_d;
      oage_q    <= oage_d;
      gate_q    <= gate_d;
      held_q    <= held_d;
      trig_q    <= trig_d;
      note_q    <= note_d;
      vel_q     <= vel_d;
    end
  end

  assign evt_ready  = rdy_q;
  assign voice_gate = gate_q;
  assign voice_note = note_q;
  assign voice_vel  = vel_q;
  assign voice_trig = trig_q;

endmodule
